// File: rtl/programmable_clock_generator.sv
// Programmable clock generator: NUM_CHANNELS independent 50%-duty divided clocks derived
// from a single input clock. Each channel has its own IDLE/RUN/STOPPING FSM. A new
// half-period is double-buffered and takes effect only at a trailing edge or when the
// channel starts from IDLE, so a reprogrammed or stopped channel never emits a runt pulse.
module programmable_clock_generator #(
    parameter int unsigned NUM_CHANNELS = 2,
    parameter int unsigned COUNT_WIDTH  = 16
) (
    input  logic                                  input_clock,
    input  logic                                  reset,
    input  logic [NUM_CHANNELS-1:0]               channel_enable,
    input  logic [NUM_CHANNELS*COUNT_WIDTH-1:0]   half_period,
    input  logic [NUM_CHANNELS-1:0]               load,
    input  logic [NUM_CHANNELS-1:0]               idle_level,
    output logic [NUM_CHANNELS-1:0]               load_pending,
    output logic [NUM_CHANNELS-1:0]               active,
    output logic [NUM_CHANNELS-1:0]               output_clock,
    output logic [NUM_CHANNELS-1:0]               rise_strobe,
    output logic [NUM_CHANNELS-1:0]               fall_strobe
);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StStopping
    } state_e;

    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_chan
        state_e                 state_q, state_d;
        logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
        logic [COUNT_WIDTH-1:0] half_q, half_d;
        logic [COUNT_WIDTH-1:0] pend_q, pend_d;
        logic                   pend_vld_q, pend_vld_d;
        logic                   active_q, active_d;
        logic                   clk_q, clk_d;
        // Idle level captured while stopped; a toggle back to it marks the trailing edge.
        logic                   pol_q, pol_d;
        logic                   rise_q, rise_d;
        logic                   fall_q, fall_d;
        logic [COUNT_WIDTH-1:0] half_in;
        logic                   toggle;
        logic                   trailing;
        logic                   apply;

        assign half_in = half_period[i*COUNT_WIDTH +: COUNT_WIDTH];

        // Next-state logic: FSM, phase counter, half-period double buffer and edge strobes.
        always_comb begin
            state_d  = state_q;
            cnt_d    = cnt_q;
            half_d   = half_q;
            clk_d    = clk_q;
            pol_d    = pol_q;
            active_d = active_q;
            toggle   = 1'b0;
            trailing = 1'b0;
            apply    = 1'b0;

            unique case (state_q)
                StIdle: begin
                    clk_d = idle_level[i];
                    pol_d = idle_level[i];
                    cnt_d = '0;
                    if (channel_enable[i]) begin
                        state_d  = StRun;
                        active_d = 1'b1;
                        apply    = pend_vld_q;
                    end
                end
                StRun, StStopping: begin
                    toggle   = (cnt_q == half_q);
                    trailing = toggle && (clk_q != pol_q);
                    if (toggle) begin
                        cnt_d = '0;
                        clk_d = ~clk_q;
                    end else begin
                        cnt_d = cnt_q + COUNT_WIDTH'(1);
                    end
                    if (trailing) begin
                        apply = pend_vld_q;
                    end
                    // Stopping only completes on a trailing edge, so the last pulse is whole.
                    if (!channel_enable[i]) begin
                        if (trailing) begin
                            state_d  = StIdle;
                            active_d = 1'b0;
                        end else begin
                            state_d = StStopping;
                        end
                    end else begin
                        state_d = StRun;
                    end
                end
                default: begin
                    state_d  = StIdle;
                    active_d = 1'b0;
                end
            endcase

            // An apply always consumes the old pending value; a coincident load stays pending.
            if (apply) begin
                half_d = pend_q;
            end
            pend_d     = load[i] ? half_in : pend_q;
            pend_vld_d = load[i] | (pend_vld_q & ~apply);

            rise_d = clk_d & ~clk_q;
            fall_d = ~clk_d & clk_q;
        end

        // Channel state registers; reset forces IDLE with every output low.
        always_ff @(posedge input_clock or negedge reset) begin
            if (!reset) begin
                state_q    <= StIdle;
                cnt_q      <= '0;
                half_q     <= '0;
                pend_q     <= '0;
                pend_vld_q <= 1'b0;
                active_q   <= 1'b0;
                clk_q      <= 1'b0;
                pol_q      <= 1'b0;
                rise_q     <= 1'b0;
                fall_q     <= 1'b0;
            end else begin
                state_q    <= state_d;
                cnt_q      <= cnt_d;
                half_q     <= half_d;
                pend_q     <= pend_d;
                pend_vld_q <= pend_vld_d;
                active_q   <= active_d;
                clk_q      <= clk_d;
                pol_q      <= pol_d;
                rise_q     <= rise_d;
                fall_q     <= fall_d;
            end
        end

        assign load_pending[i] = pend_vld_q;
        assign active[i]       = active_q;
        assign output_clock[i] = clk_q;
        assign rise_strobe[i]  = rise_q;
        assign fall_strobe[i]  = fall_q;
    end

endmodule

// File: tb/tb_programmable_clock_generator.sv
// Directed bench for programmable_clock_generator: a per-cycle vector table for the basic
// divide sequence, then hand-written sequences for divide extremes, glitch-free reload,
// stop/restart, polarity, independence and asynchronous reset.
module tb_programmable_clock_generator;

    localparam int unsigned NCH = 2;
    localparam int unsigned CW  = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [NCH-1:0]    channel_enable = '0;
    logic [NCH*CW-1:0] half_period = '0;
    logic [NCH-1:0]    load = '0;
    logic [NCH-1:0]    idle_level = '0;
    logic [NCH-1:0]    load_pending;
    logic [NCH-1:0]    active;
    logic [NCH-1:0]    output_clock;
    logic [NCH-1:0]    rise_strobe;
    logic [NCH-1:0]    fall_strobe;

    int tests  = 0;
    int errors = 0;

    programmable_clock_generator #(
        .NUM_CHANNELS (NCH),
        .COUNT_WIDTH  (CW)
    ) dut (
        .input_clock    (clk),
        .reset          (reset),
        .channel_enable (channel_enable),
        .half_period    (half_period),
        .load           (load),
        .idle_level     (idle_level),
        .load_pending   (load_pending),
        .active         (active),
        .output_clock   (output_clock),
        .rise_strobe    (rise_strobe),
        .fall_strobe    (fall_strobe)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] ld;
        logic [3:0] h0;
        logic [1:0] en;
        logic [1:0] e_out;
        logic [1:0] e_act;
        logic [1:0] e_pend;
        logic [1:0] e_rise;
        logic [1:0] e_fall;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, " output_clock"}, int'(output_clock), 0);
        chk({name, " active"}, int'(active), 0);
        chk({name, " load_pending"}, int'(load_pending), 0);
        chk({name, " rise_strobe"}, int'(rise_strobe), 0);
        chk({name, " fall_strobe"}, int'(fall_strobe), 0);
    endtask

    task automatic do_reset();
        reset          = 1'b0;
        channel_enable = '0;
        load           = '0;
        half_period    = '0;
        idle_level     = '0;
        step();
        chk_all_zero("in reset");
        reset = 1'b1;
    endtask

    // Waits (bounded) for the next rise/fall strobe on channel ch and checks the distance.
    task automatic wait_edge(input int ch, input bit rising, input int exp_cycles,
                             input string name);
        int n     = 0;
        int other = 0;
        bit seen  = 1'b0;
        while (!seen && n < 100) begin
            step();
            n++;
            if (rising ? rise_strobe[ch] : fall_strobe[ch]) seen = 1'b1;
            else if (rising ? fall_strobe[ch] : rise_strobe[ch]) other++;
        end
        chk({name, " seen"}, int'(seen), 1);
        chk({name, " cycles"}, n, exp_cycles);
        chk({name, " level"}, int'(output_clock[ch]), int'(rising));
        chk({name, " stray strobes"}, other, 0);
    endtask

    // Loads a half-period into channel 0, then enables it; returns on the first active cycle.
    task automatic start_ch0(input logic [3:0] h);
        load[0]          = 1'b1;
        half_period[3:0] = h;
        step();
        load[0]           = 1'b0;
        channel_enable[0] = 1'b1;
        step();
        chk("start active", int'(active[0]), 1);
        chk("start pending cleared", int'(load_pending[0]), 0);
    endtask

    initial begin
        // ld, h0, en, out, act, pend, rise, fall
        vecs[0]  = '{2'b01, 4'd3, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00};
        vecs[1]  = '{2'b00, 4'd3, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00};
        vecs[2]  = '{2'b00, 4'd3, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00};
        vecs[3]  = '{2'b00, 4'd3, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00};
        vecs[4]  = '{2'b00, 4'd3, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00};
        vecs[5]  = '{2'b00, 4'd3, 2'b01, 2'b01, 2'b01, 2'b00, 2'b01, 2'b00};
        vecs[6]  = '{2'b00, 4'd3, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00};
        vecs[7]  = '{2'b00, 4'd3, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00};
        vecs[8]  = '{2'b00, 4'd3, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00};
        vecs[9]  = '{2'b00, 4'd3, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01};
        vecs[10] = '{2'b00, 4'd3, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00};
        vecs[11] = '{2'b00, 4'd3, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00};
        vecs[12] = '{2'b00, 4'd3, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00};
        vecs[13] = '{2'b00, 4'd3, 2'b01, 2'b01, 2'b01, 2'b00, 2'b01, 2'b00};

        // Reset state, then single-channel divide by 8 (half = 3).
        do_reset();
        for (int i = 0; i < 14; i++) begin
            load             = vecs[i].ld;
            half_period[3:0] = vecs[i].h0;
            channel_enable   = vecs[i].en;
            step();
            chk($sformatf("vec%0d output_clock", i), int'(output_clock), int'(vecs[i].e_out));
            chk($sformatf("vec%0d active", i), int'(active), int'(vecs[i].e_act));
            chk($sformatf("vec%0d load_pending", i), int'(load_pending), int'(vecs[i].e_pend));
            chk($sformatf("vec%0d rise_strobe", i), int'(rise_strobe), int'(vecs[i].e_rise));
            chk($sformatf("vec%0d fall_strobe", i), int'(fall_strobe), int'(vecs[i].e_fall));
        end
        for (int p = 0; p < 2; p++) begin
            wait_edge(0, 1'b0, 4, "div8 fall");
            wait_edge(0, 1'b1, 4, "div8 rise");
        end

        // Divide extremes: half = 0 (toggle every cycle) and half = 15 (32-cycle period).
        do_reset();
        start_ch0(4'd0);
        wait_edge(0, 1'b1, 1, "div2 lead");
        for (int p = 0; p < 4; p++) begin
            wait_edge(0, 1'b0, 1, "div2 fall");
            wait_edge(0, 1'b1, 1, "div2 rise");
        end
        do_reset();
        start_ch0(4'd15);
        wait_edge(0, 1'b1, 16, "div32 lead");
        for (int p = 0; p < 4; p++) begin
            wait_edge(0, 1'b0, 16, "div32 fall");
            wait_edge(0, 1'b1, 16, "div32 rise");
        end

        // Glitch-free reload: half 5 -> 1 loaded two cycles into the high phase.
        do_reset();
        start_ch0(4'd5);
        wait_edge(0, 1'b1, 6, "reload lead");
        step();
        step();
        load[0]          = 1'b1;
        half_period[3:0] = 4'd1;
        step();
        load[0] = 1'b0;
        chk("reload pending set", int'(load_pending[0]), 1);
        wait_edge(0, 1'b0, 3, "reload old-period trailing");
        chk("reload pending cleared", int'(load_pending[0]), 0);
        wait_edge(0, 1'b1, 2, "reload new rise");
        wait_edge(0, 1'b0, 2, "reload new fall");

        // Clean stop two cycles into the high phase.
        do_reset();
        start_ch0(4'd3);
        wait_edge(0, 1'b1, 4, "stop lead");
        step();
        step();
        channel_enable[0] = 1'b0;
        step();
        chk("stopping still active", int'(active[0]), 1);
        chk("stopping still high", int'(output_clock[0]), 1);
        wait_edge(0, 1'b0, 1, "stop trailing");
        chk("stop active low", int'(active[0]), 0);
        for (int k = 0; k < 6; k++) begin
            step();
            chk($sformatf("stopped%0d output", k), int'(output_clock[0]), 0);
            chk($sformatf("stopped%0d active", k), int'(active[0]), 0);
            chk($sformatf("stopped%0d rise", k), int'(rise_strobe[0]), 0);
        end

        // Restart, then drop and re-raise enable inside STOPPING: phase must not move.
        channel_enable[0] = 1'b1;
        step();
        chk("restart active", int'(active[0]), 1);
        wait_edge(0, 1'b1, 4, "restart lead");
        step();
        channel_enable[0] = 1'b0;
        step();
        channel_enable[0] = 1'b1;
        wait_edge(0, 1'b0, 2, "resume fall");
        chk("resume active", int'(active[0]), 1);
        wait_edge(0, 1'b1, 4, "resume rise");

        // Polarity and independence: ch1 idles high (half 2), ch0 idles low (half 4).
        do_reset();
        idle_level = 2'b10;
        step();
        chk("idle follow output", int'(output_clock), 2);
        chk("idle follow rise", int'(rise_strobe), 2);
        load        = 2'b11;
        half_period = {4'd2, 4'd4};
        step();
        load           = 2'b00;
        channel_enable = 2'b11;
        step();
        for (int k = 0; k < 20; k++) begin
            // Channel with half h and idle p at active cycle k: p ^ ((k / (h+1)) odd).
            logic e0, e1;
            e0 = 1'b0 ^ ((k / 5) % 2 == 1);
            e1 = 1'b1 ^ ((k / 3) % 2 == 1);
            chk($sformatf("dual k%0d ch0", k), int'(output_clock[0]), int'(e0));
            chk($sformatf("dual k%0d ch1", k), int'(output_clock[1]), int'(e1));
            chk($sformatf("dual k%0d active", k), int'(active), 3);
            if (k == 5) idle_level = 2'b00;
            step();
        end

        // Asynchronous reset mid-run: outputs drop before the next clock edge.
        #2;
        reset = 1'b0;
        #1;
        chk_all_zero("async reset");
        step();
        step();
        chk_all_zero("held reset");

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/programmable_clock_generator.md
PROGRAMMABLE_CLOCK_GENERATOR -- requirements
Module: programmable_clock_generator

Interface
REQ-001 The block SHALL have parameter NUM_CHANNELS, default 2, giving the number of independent divided-clock channels (1..8).
REQ-002 The block SHALL have parameter COUNT_WIDTH, default 16, giving the width of each channel's half-period count (2..32).
REQ-003 The block SHALL have port input_clock, input, 1, the single clock; all state SHALL be on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port channel_enable, input, NUM_CHANNELS, where bit i requests channel i to run.
REQ-006 The block SHALL have port half_period, input, NUM_CHANNELS*COUNT_WIDTH, where channel i uses bits [i*COUNT_WIDTH +: COUNT_WIDTH] as the requested half-period minus one.
REQ-007 The block SHALL have port load, input, NUM_CHANNELS, where a one-cycle pulse on bit i captures channel i's half_period into its pending register.
REQ-008 The block SHALL have port idle_level, input, NUM_CHANNELS, giving channel i's output level while stopped (clock polarity).
REQ-009 The block SHALL have port load_pending, output, NUM_CHANNELS, high while channel i holds a captured value not yet applied.
REQ-010 The block SHALL have port active, output, NUM_CHANNELS, high while channel i is in RUN or STOPPING.
REQ-011 The block SHALL have port output_clock, output, NUM_CHANNELS, the registered divided clock for each channel.
REQ-012 The block SHALL have ports rise_strobe and fall_strobe, output, NUM_CHANNELS, each high for exactly the first input_clock cycle in which output_clock(i) is 1 or 0 respectively after a transition.

Function
REQ-013 Each channel SHALL be independent, with its own FSM (IDLE, RUN, STOPPING), counter, active half-period register and pending register.
REQ-014 In IDLE, output_clock SHALL equal the idle_level sampled on the previous cycle, and the counter SHALL be 0.
REQ-015 On IDLE with channel_enable high, the channel SHALL apply any pending value, clear load_pending, enter RUN with counter 0 on the next cycle, and assert active on that cycle.
REQ-016 In RUN, the counter SHALL increment each cycle; when counter equals the active half-period, output_clock SHALL toggle and the counter SHALL return to 0, giving phases of (half+1) cycles, a period of 2*(half+1) cycles and exactly 50% duty.
REQ-017 The first toggle after entering RUN SHALL move output_clock away from idle_level (the leading edge) after half+1 cycles in RUN.
REQ-018 A toggle back to idle_level SHALL be the trailing edge; pending values SHALL be applied only at a trailing edge or in IDLE, never mid-period.
REQ-019 Half-period value 0 SHALL give divide-by-2 (toggle every cycle); the maximum value SHALL give divide-by-2^(COUNT_WIDTH+1) with no counter overflow.
REQ-020 A load pulse SHALL overwrite the pending register (latest wins) and set load_pending on the next cycle.
REQ-021 If a load coincides with an apply, the apply SHALL use the previously pending value, and the new value SHALL remain pending with load_pending high.
REQ-022 Deassertion of channel_enable in RUN SHALL move the channel to STOPPING, which counts as RUN until the next trailing edge, then enters IDLE; no runt pulse SHALL ever be produced.
REQ-023 Reassertion of channel_enable in STOPPING SHALL return the channel to RUN without disturbing the counter or the phase.
REQ-024 idle_level SHALL be sampled only in IDLE; a change while active SHALL take effect after the channel returns to IDLE.
REQ-025 All outputs SHALL be driven from flops; input_clock SHALL never be muxed or gated onto output_clock.

Reset
REQ-026 When reset is low, every channel SHALL immediately enter IDLE, and all of counter, active half-period, pending, load_pending, active, output_clock, rise_strobe and fall_strobe SHALL be 0.
REQ-027 After reset release, output_clock SHALL follow idle_level from the next cycle; an assertion of reset mid-period SHALL truncate the output with no further edges.

Verification
REQ-028 Single-channel frequency: NUM_CHANNELS=2; channel 0 loads half=3, idle_level=0, enable -> first rise 4 cycles after active, 8-cycle period, 4 cycles high; one rise_strobe and one fall_strobe per period.
REQ-029 Divide extremes: half=0 gives toggling every cycle; half=2^COUNT_WIDTH-1 with COUNT_WIDTH=4 gives a 32-cycle period -> both verified over 4 periods.
REQ-030 Glitch-free update: while running at half=5, load half=1 mid-high-phase -> the current period completes at 12 cycles, the next period is 4 cycles, and load_pending clears at the trailing edge.
REQ-031 Clean stop and restart: drop enable 2 cycles into the high phase -> the high phase completes, output returns to 0, then active deasserts; re-enable in STOPPING -> phase continues unchanged.
REQ-032 Polarity and independence: channel 1 idle_level=1, half=2, channel 0 half=4, both enabled -> channel 1 idles high with a falling leading edge, channel 0 is unaffected; async reset mid-run -> all outputs 0 immediately.
